// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read, dual-write register file.
// Sits between decode (combinational read ports) and the two writeback lanes.
// After reset the array is cleared one entry per clock. Writes are accepted,
// and reads return array data, only once that sweep has finished.
module regfile_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int NUM_READ = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_READ*AW-1:0]    read_addr,
  output logic [NUM_READ*WIDTH-1:0] read_data,
  input  logic                      we0,
  input  logic [AW-1:0]             waddr0,
  input  logic [WIDTH-1:0]          wdata0,
  input  logic                      we1,
  input  logic [AW-1:0]             waddr1,
  input  logic [WIDTH-1:0]          wdata1,
  output logic                      ready,
  output logic                      wr_conflict
);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // One extra bit, so that DEPTH itself is representable for range checks.
  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t           state_q;
  logic [AW-1:0]    clr_ptr_q;
  logic             ready_q;
  logic             wr_conflict_q;
  logic [WIDTH-1:0] rf_q [DEPTH];

  logic run;
  logic wr0_ok;
  logic wr1_ok;
  logic wr_conflict_d;

  // An address is usable when it is inside the array.
  // With ZERO_REG set, it must also not be the hardwired zero entry.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    addr_ok = ({1'b0, a} < DEPTH_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // Writes only count in RUN, and are suppressed while reset is asserted.
  assign run           = (state_q == ST_RUN) && !reset;
  assign wr0_ok        = run && we0 && addr_ok(waddr0);
  assign wr1_ok        = run && we1 && addr_ok(waddr1);
  assign wr_conflict_d = wr0_ok && wr1_ok && (waddr0 == waddr1);

  // Control FSM: INIT sweeps clr_ptr across the array, then RUN until reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_INIT;
      clr_ptr_q     <= '0;
      ready_q       <= 1'b0;
      wr_conflict_q <= 1'b0;
    end else begin
      wr_conflict_q <= wr_conflict_d;
      case (state_q)
        ST_INIT: begin
          clr_ptr_q <= clr_ptr_q + AW'(1);
          if (clr_ptr_q == LAST_ADDR) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  // Array update: the clearing sweep in INIT, and the two write lanes in RUN.
  // Port 1 is written last, so it wins when both ports hit the same entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (state_q == ST_INIT) begin
        rf_q[clr_ptr_q] <= '0;
      end else begin
        if (wr0_ok) rf_q[waddr0] <= wdata0;
        if (wr1_ok) rf_q[waddr1] <= wdata1;
      end
    end
  end

  // Read ports are combinational, with optional same-cycle forwarding.
  for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = read_addr[gi*AW +: AW];

    // Priority: not ready, unusable address, port 1 forward, port 0 forward, array.
    always_comb begin
      rd = '0;
      if (!ready_q || reset || !addr_ok(ra)) begin
        rd = '0;
      end else if ((BYPASS != 0) && wr1_ok && (waddr1 == ra)) begin
        rd = wdata1;
      end else if ((BYPASS != 0) && wr0_ok && (waddr0 == ra)) begin
        rd = wdata0;
      end else begin
        rd = rf_q[ra];
      end
    end

    assign read_data[gi*WIDTH +: WIDTH] = rd;
  end

  assign ready       = ready_q;
  assign wr_conflict = wr_conflict_q;

endmodule
